// File: rtl/dmem_responder_pkg.sv
// Shared defines for the data-memory responder: bus widths, FSM state type
// and the request latch captured at acceptance.
package dmem_responder_pkg;

  localparam int XLEN  = 32;
  localparam int BYTES = XLEN / 8;

  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  typedef struct packed {
    data_t            addr;
    logic             we;
    logic [BYTES-1:0] be;
    data_t            wdata;
    logic             lr;
    logic             sc;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between an initiator (master) and the data-memory
// responder (slave).
// Handshake: a request transfers on a rising edge where req_valid && req_ready;
// resp_valid is a one-cycle strobe with no backpressure, and the resp_* data
// fields read as zero whenever resp_valid is low.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic             req_valid;
  logic             req_ready;
  data_t            req_addr;
  logic             req_we;
  logic [BYTES-1:0] req_be;
  data_t            req_wdata;
  logic             req_lr;
  logic             req_sc;
  logic             resp_valid;
  data_t            resp_rdata;
  logic             resp_err;
  logic             resp_sc_fail;

  modport master (
    output req_valid, req_addr, req_we, req_be, req_wdata, req_lr, req_sc,
    input  req_ready, resp_valid, resp_rdata, resp_err, resp_sc_fail
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_be, req_wdata, req_lr, req_sc,
    output req_ready, resp_valid, resp_rdata, resp_err, resp_sc_fail
  );
endinterface

// File: rtl/dmem_responder_sram.sv
// Single-port word store: synchronous per-lane write, combinational read.
// No reset, so contents survive the responder's reset.
module dmem_sram
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = 12
) (
  input  logic             clk,
  input  logic [AW-1:0]    addr,
  input  logic [BYTES-1:0] we,
  input  data_t            wdata,
  output data_t            rdata
);

  data_t mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder: IDLE -> WAIT -> RESP FSM in front of
// dmem_sram. Optional LR/SC reservation support is built under DMEM_LRSC_EN.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  dmem_responder_if.slave        bus,
  output dmem_state_t            dbg_state
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_t      state, state_nx;
  logic [3:0]       cnt;
  dmem_req_t        req_q;
  logic             accept, in_resp, fault, sc_fail, mem_we;
  logic [BYTES-1:0] lane_we;
  data_t            mem_rdata;

  assign bus.req_ready = (state == IDLE) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign in_resp       = (state == RESP);
  assign dbg_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      req_q <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        req_q <= '{addr: bus.req_addr, we: bus.req_we, be: bus.req_be,
                   wdata: bus.req_wdata, lr: bus.req_lr, sc: bus.req_sc};
        cnt   <= 4'((LATENCY > 1) ? LATENCY - 2 : 0);
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = (LATENCY > 1) ? WAIT : RESP;
      WAIT:    if (cnt == 4'd0) state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign fault = (req_q.addr[1:0] != 2'b00) ||
                 ({2'b00, req_q.addr[XLEN-1:2]} >= XLEN'(DEPTH_WORDS));

`ifdef DMEM_LRSC_EN
  logic            resv_valid;
  logic [XLEN-3:0] resv_addr;
  logic            resv_hit;

  assign resv_hit = resv_valid && (resv_addr == req_q.addr[XLEN-1:2]);
  assign sc_fail  = req_q.we && req_q.sc && !resv_hit;

  // Any non-faulting SC, or a plain store hitting the reserved word, drops it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resv_valid <= 1'b0;
      resv_addr  <= '0;
    end else if (in_resp && !fault) begin
      if (!req_q.we && req_q.lr) begin
        resv_valid <= 1'b1;
        resv_addr  <= req_q.addr[XLEN-1:2];
      end else if (req_q.we && (req_q.sc || resv_hit)) begin
        resv_valid <= 1'b0;
      end
    end
  end
`else
  logic unused_lrsc;
  assign unused_lrsc = req_q.lr ^ req_q.sc;
  assign sc_fail     = 1'b0;
`endif

  assign mem_we  = in_resp && req_q.we && !fault && !sc_fail;
  assign lane_we = mem_we ? req_q.be : '0;

  dmem_sram #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_sram (
    .clk   (clk),
    .addr  (req_q.addr[AW+1:2]),
    .we    (lane_we),
    .wdata (req_q.wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    bus.resp_valid   = 1'b0;
    bus.resp_rdata   = '0;
    bus.resp_err     = 1'b0;
    bus.resp_sc_fail = 1'b0;
    if (in_resp) begin
      bus.resp_valid = 1'b1;
      bus.resp_err   = fault;
      if (!fault) begin
        if (req_q.we) begin
          bus.resp_sc_fail = sc_fail;
          bus.resp_rdata   = sc_fail ? data_t'(1) : '0;
        end else begin
          bus.resp_rdata = mem_rdata;
        end
      end
    end
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 4096: number of 32-bit words in the data store.
REQ-002 SHALL have parameter LATENCY, default 2: cycles from request acceptance to response; legal range 1..15.
REQ-003 SHALL have port clk, input, 1: core clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1: a request is present.
REQ-006 SHALL have port req_ready, output, 1: the responder can accept a request.
REQ-007 SHALL have port req_addr, input, XLEN: byte address.
REQ-008 SHALL have port req_we, input, 1: 1 = store, 0 = load.
REQ-009 SHALL have port req_be, input, BYTES: byte-lane enables; be[i] gates wdata[8i+7:8i].
REQ-010 SHALL have port req_wdata, input, XLEN: store data, already lane-placed by the initiator.
REQ-011 SHALL have port req_lr, input, 1: load-reserved qualifier (valid only with req_we=0).
REQ-012 SHALL have port req_sc, input, 1: store-conditional qualifier (valid only with req_we=1).
REQ-013 SHALL have port resp_valid, output, 1: single-cycle response strobe; no backpressure.
REQ-014 SHALL have port resp_rdata, output, XLEN: load data, or the SC result code.
REQ-015 SHALL have port resp_err, output, 1: access fault.
REQ-016 SHALL have port resp_sc_fail, output, 1: store-conditional failed.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> RESP -> IDLE. A request is accepted when req_valid&&req_ready. IDLE goes to WAIT when LATENCY>1, or directly to RESP when LATENCY=1.
REQ-018 SHALL assert req_ready only in IDLE; throughput is one request per LATENCY+1 cycles.
REQ-019 SHALL latch addr, we, be, wdata, lr and sc at acceptance; later input changes have no effect on that request.
REQ-020 SHALL count down LATENCY-1 cycles in WAIT, then enter RESP; resp_valid is high for exactly the one RESP cycle, LATENCY cycles after acceptance.
REQ-021 SHALL flag an access fault when addr[1:0]!=0 or addr[XLEN-1:2]>=DEPTH_WORDS. A faulting request gives resp_err=1 and resp_rdata=0, and performs no write and no reservation change.
REQ-022 SHALL return the full stored word on a load, regardless of be.
REQ-023 SHALL commit a store on the RESP cycle, to enabled lanes only; a store with be=0 is a legal no-op; a store response gives resp_rdata=0.
REQ-024 SHALL hold resp_rdata, resp_err and resp_sc_fail at 0 whenever resp_valid=0.

Reset
REQ-025 SHALL, on rst, go to IDLE, clear the counter and reservation, and drive req_ready=0 while rst is high, then req_ready=1 in the first cycle after release.
REQ-026 SHALL abort an in-flight request on rst in WAIT or RESP: no write commits and no response is issued.
REQ-027 SHALL leave storage contents unaffected by rst.

Configuration
REQ-028 SHALL compile in LR/SC support under macro DMEM_LRSC_EN.
REQ-029 SHALL, with DMEM_LRSC_EN defined, handle LR/SC as follows:
- LR sets reservation {valid, word address}.
- SC succeeds only if valid and address match: write commits, resp_sc_fail=0, resp_rdata=0.
- Otherwise SC does not write: resp_sc_fail=1, resp_rdata=1.
- Every non-faulting SC clears the reservation.
- A plain store to the reserved word clears it.
- A newer LR replaces it.
REQ-030 SHALL, without DMEM_LRSC_EN, treat req_lr as a plain load and req_sc as a plain store, tie resp_sc_fail to 0, and keep all ports present.

Structure
REQ-031 SHALL place dmem_state_t (IDLE/WAIT/RESP) and a packed dmem_req_t latch struct in the shared defines package, reusing data_t, BYTES and XLEN.
REQ-032 SHALL instantiate one sub-module, dmem_sram: DEPTH_WORDS x XLEN array, one read/write port, per-lane write enable, synchronous write, combinational read.

Verification
REQ-033 SHALL cover: LATENCY=2, store 0xDEADBEEF to 0x40 with be=4'b1111, then load 0x40 -> resp_valid exactly 2 cycles after each accept; rdata=0xDEADBEEF.
REQ-034 SHALL cover: store 0x000000AA to 0x40 with be=4'b0001 over 0xDEADBEEF, then load -> 0xDEADBEAA.
REQ-035 SHALL cover: load 0x42 and load at byte address DEPTH_WORDS*4 -> resp_err=1, rdata=0; a prior word at 0x40 is unchanged.
REQ-036 SHALL cover, with DMEM_LRSC_EN: LR 0x80, then SC 0x80 data 5 -> sc_fail=0, mem[0x80]=5; a second SC 0x80 data 6 -> sc_fail=1, rdata=1, mem[0x80]=5.
REQ-037 SHALL cover, with DMEM_LRSC_EN: LR 0x80, store 0x80 data 9, then SC 0x80 data 7 -> sc_fail=1, mem[0x80]=9.
REQ-038 SHALL cover: rst pulsed one cycle after accepting a store of 0x1234 to 0x10 -> no resp_valid; mem[0x10] keeps its old value; req_ready=1 one cycle after rst release.
